// File: rtl/rr_wormhole_arb.sv
// Round-robin output-port arbiter with wormhole packet locking.
// Candidates are requests gated by downstream eligibility. A grant is
// registered and held until the packet releases it. The priority pointer
// then moves to the port just after the released one.
module rr_wormhole_arb #(
   parameter int NUM_PORTS = 5,
   parameter int IDX_W     = 3,
   parameter bit LOCK_EN   = 1'b1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NUM_PORTS-1:0] req_i,
   input  logic [NUM_PORTS-1:0] elig_i,
   input  logic                 advance_i,
   input  logic                 tail_i,
   output logic [NUM_PORTS-1:0] grant_o,
   output logic [IDX_W-1:0]     grant_idx_o,
   output logic                 grant_valid_o
);

   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] BUSY = 1'b1;

   localparam logic [IDX_W-1:0] NO_GRANT = '1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_PORTS - 1);

   logic [0:0]           state_q, state_d;
   logic [IDX_W-1:0]     ptr_q, ptr_d;
   logic [IDX_W-1:0]     idx_q, idx_d;
   logic [NUM_PORTS-1:0] grant_q, grant_d;

   logic [NUM_PORTS-1:0] cand;
   logic                 release_c;
   logic [IDX_W-1:0]     ptr_after;
   logic [IDX_W-1:0]     start;
   logic                 win_found;
   logic [IDX_W-1:0]     win_idx;
   logic [NUM_PORTS-1:0] win_oh;

   assign cand      = req_i & elig_i;
   assign release_c = advance_i & (LOCK_EN ? tail_i : 1'b1);
   assign ptr_after = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
   // A releasing packet re-arbitrates in the same cycle from the rotated pointer,
   // so back-to-back packets see no bubble.
   assign start     = (state_q == BUSY && release_c) ? ptr_after : ptr_q;

   // Circular first-set search: ports start..N-1 first, then 0..start-1.
   always_comb begin
      win_found = 1'b0;
      win_idx   = NO_GRANT;
      win_oh    = '0;
      for (int unsigned k = 0; k < NUM_PORTS; k++) begin
         if (!win_found && cand[k] && k >= 32'(start)) begin
            win_found = 1'b1;
            win_idx   = IDX_W'(k);
         end
      end
      for (int unsigned k = 0; k < NUM_PORTS; k++) begin
         if (!win_found && cand[k] && k < 32'(start)) begin
            win_found = 1'b1;
            win_idx   = IDX_W'(k);
         end
      end
      for (int unsigned k = 0; k < NUM_PORTS; k++) begin
         if (win_found && win_idx == IDX_W'(k)) begin
            win_oh[k] = 1'b1;
         end
      end
   end

   // Next-state logic: acquire from IDLE, hold or hand over in BUSY.
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      idx_d   = idx_q;
      grant_d = grant_q;
      case (state_q)
         IDLE: begin
            if (win_found) begin
               state_d = BUSY;
               idx_d   = win_idx;
               grant_d = win_oh;
            end
         end
         BUSY: begin
            if (release_c) begin
               ptr_d = ptr_after;
               if (win_found) begin
                  idx_d   = win_idx;
                  grant_d = win_oh;
               end else begin
                  state_d = IDLE;
                  idx_d   = NO_GRANT;
                  grant_d = '0;
               end
            end
         end
         default: begin
            state_d = IDLE;
            idx_d   = NO_GRANT;
            grant_d = '0;
         end
      endcase
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         ptr_q   <= '0;
         idx_q   <= NO_GRANT;
         grant_q <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         idx_q   <= idx_d;
         grant_q <= grant_d;
      end
   end

   assign grant_o       = grant_q;
   assign grant_idx_o   = idx_q;
   assign grant_valid_o = (state_q == BUSY);

endmodule

// File: tb/tb_rr_wormhole_arb.sv
// Self-checking bench for rr_wormhole_arb: a vector table on the default
// configuration, plus hand sequences for LOCK_EN=0 and an 8-port instance.
module tb_rr_wormhole_arb;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_fail = 0;
   logic chk_en = 1'b0;

   // Instance A: defaults (5 ports, lock enabled)
   logic       rst_a, adv_a, tail_a;
   logic [4:0] req_a, elig_a, grant_a;
   logic [2:0] idx_a;
   logic       gv_a;

   // Instance B: 5 ports, lock disabled
   logic       rst_b, adv_b, tail_b;
   logic [4:0] req_b, elig_b, grant_b;
   logic [2:0] idx_b;
   logic       gv_b;

   // Instance C: 8 ports, 4-bit index
   logic       rst_c, adv_c, tail_c;
   logic [7:0] req_c, elig_c, grant_c;
   logic [3:0] idx_c;
   logic       gv_c;

   rr_wormhole_arb dut_a (
      .clk(clk), .rst(rst_a), .req_i(req_a), .elig_i(elig_a),
      .advance_i(adv_a), .tail_i(tail_a), .grant_o(grant_a),
      .grant_idx_o(idx_a), .grant_valid_o(gv_a));

   rr_wormhole_arb #(.NUM_PORTS(5), .IDX_W(3), .LOCK_EN(1'b0)) dut_b (
      .clk(clk), .rst(rst_b), .req_i(req_b), .elig_i(elig_b),
      .advance_i(adv_b), .tail_i(tail_b), .grant_o(grant_b),
      .grant_idx_o(idx_b), .grant_valid_o(gv_b));

   rr_wormhole_arb #(.NUM_PORTS(8), .IDX_W(4), .LOCK_EN(1'b1)) dut_c (
      .clk(clk), .rst(rst_c), .req_i(req_c), .elig_i(elig_c),
      .advance_i(adv_c), .tail_i(tail_c), .grant_o(grant_c),
      .grant_idx_o(idx_c), .grant_valid_o(gv_c));

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   // Every cycle: one-hot grant must match the index, idle must show all-ones.
   always @(negedge clk) begin
      if (chk_en) begin
         if (gv_a) check("a_onehot", 32'(grant_a), 32'(5'd1 << idx_a));
         else begin
            check("a_idle_grant", 32'(grant_a), 32'd0);
            check("a_idle_idx", 32'(idx_a), 32'd7);
         end
         if (gv_b) check("b_onehot", 32'(grant_b), 32'(5'd1 << idx_b));
         else begin
            check("b_idle_grant", 32'(grant_b), 32'd0);
            check("b_idle_idx", 32'(idx_b), 32'd7);
         end
         if (gv_c) check("c_onehot", 32'(grant_c), 32'(8'd1 << idx_c));
         else begin
            check("c_idle_grant", 32'(grant_c), 32'd0);
            check("c_idle_idx", 32'(idx_c), 32'd15);
         end
      end
   end

   typedef struct {
      logic       rst;
      logic [4:0] req;
      logic [4:0] elig;
      logic       adv;
      logic       tail;
      logic [2:0] exp_idx;
      logic       exp_v;
   } vec_t;

   vec_t tv[$];

   task automatic step_b(input logic r, input logic [4:0] rq, input logic ad, input logic tl,
                         input logic [2:0] ei, input logic ev, input string name);
      logic [4:0] eg;
      @(negedge clk);
      rst_b = r; req_b = rq; elig_b = 5'b11111; adv_b = ad; tail_b = tl;
      @(posedge clk); #1;
      eg = ev ? (5'd1 << ei) : 5'd0;
      check({name, "_idx"}, 32'(idx_b), 32'(ei));
      check({name, "_v"}, 32'(gv_b), 32'(ev));
      check({name, "_grant"}, 32'(grant_b), 32'(eg));
   endtask

   task automatic step_c(input logic r, input logic [7:0] rq, input logic ad, input logic tl,
                         input logic [3:0] ei, input logic ev, input string name);
      logic [7:0] eg;
      @(negedge clk);
      rst_c = r; req_c = rq; elig_c = 8'hFF; adv_c = ad; tail_c = tl;
      @(posedge clk); #1;
      eg = ev ? (8'd1 << ei) : 8'd0;
      check({name, "_idx"}, 32'(idx_c), 32'(ei));
      check({name, "_v"}, 32'(gv_c), 32'(ev));
      check({name, "_grant"}, 32'(grant_c), 32'(eg));
   endtask

   initial begin
      logic [4:0] eg;
      rst_a = 1'b1; req_a = '0; elig_a = '0; adv_a = 1'b0; tail_a = 1'b0;
      rst_b = 1'b1; req_b = '0; elig_b = '0; adv_b = 1'b0; tail_b = 1'b0;
      rst_c = 1'b1; req_c = '0; elig_c = '0; adv_c = 1'b0; tail_c = 1'b0;

      //            rst   req       elig      adv   tail  idx   v
      tv.push_back('{1'b1, 5'b00000, 5'b11111, 1'b0, 1'b0, 3'd7, 1'b0}); // reset
      tv.push_back('{1'b0, 5'b00000, 5'b11111, 1'b0, 1'b0, 3'd7, 1'b0}); // idle, no req
      tv.push_back('{1'b0, 5'b00000, 5'b11111, 1'b1, 1'b1, 3'd7, 1'b0}); // adv/tail ignored in idle
      tv.push_back('{1'b0, 5'b00100, 5'b11111, 1'b0, 1'b0, 3'd2, 1'b1}); // single req -> 2
      tv.push_back('{1'b0, 5'b00100, 5'b11111, 1'b0, 1'b0, 3'd2, 1'b1}); // hold
      tv.push_back('{1'b0, 5'b00000, 5'b11111, 1'b1, 1'b1, 3'd7, 1'b0}); // release, nobody -> idle
      tv.push_back('{1'b1, 5'b00000, 5'b11111, 1'b0, 1'b0, 3'd7, 1'b0}); // reset, ptr=0
      tv.push_back('{1'b0, 5'b11111, 5'b11111, 1'b1, 1'b1, 3'd0, 1'b1}); // rotation 0
      tv.push_back('{1'b0, 5'b11111, 5'b11111, 1'b1, 1'b1, 3'd1, 1'b1}); // 1
      tv.push_back('{1'b0, 5'b11111, 5'b11111, 1'b1, 1'b1, 3'd2, 1'b1}); // 2
      tv.push_back('{1'b0, 5'b11111, 5'b11111, 1'b1, 1'b1, 3'd3, 1'b1}); // 3
      tv.push_back('{1'b0, 5'b11111, 5'b11111, 1'b1, 1'b1, 3'd4, 1'b1}); // 4
      tv.push_back('{1'b0, 5'b11111, 5'b11111, 1'b1, 1'b1, 3'd0, 1'b1}); // wrap to 0
      tv.push_back('{1'b0, 5'b00010, 5'b11111, 1'b1, 1'b1, 3'd1, 1'b1}); // grant 1
      tv.push_back('{1'b0, 5'b11111, 5'b11111, 1'b1, 1'b0, 3'd1, 1'b1}); // body flit
      tv.push_back('{1'b0, 5'b11111, 5'b11111, 1'b1, 1'b0, 3'd1, 1'b1}); // body flit
      tv.push_back('{1'b0, 5'b11101, 5'b11111, 1'b1, 1'b0, 3'd1, 1'b1}); // req[1] drops, held
      tv.push_back('{1'b0, 5'b11111, 5'b11111, 1'b1, 1'b1, 3'd2, 1'b1}); // tail -> 2
      tv.push_back('{1'b1, 5'b00000, 5'b11111, 1'b0, 1'b0, 3'd7, 1'b0}); // reset
      tv.push_back('{1'b0, 5'b01010, 5'b00010, 1'b0, 1'b0, 3'd1, 1'b1}); // elig mask -> 1
      tv.push_back('{1'b0, 5'b01010, 5'b01000, 1'b1, 1'b1, 3'd3, 1'b1}); // tail, elig 3 -> 3
      tv.push_back('{1'b0, 5'b01010, 5'b00000, 1'b1, 1'b1, 3'd7, 1'b0}); // tail, cand=0 -> idle, ptr=4
      tv.push_back('{1'b0, 5'b01010, 5'b11111, 1'b0, 1'b0, 3'd1, 1'b1}); // from ptr 4 -> 1
      tv.push_back('{1'b0, 5'b00010, 5'b11111, 1'b1, 1'b1, 3'd1, 1'b1}); // sole cand re-granted
      tv.push_back('{1'b0, 5'b01010, 5'b11111, 1'b1, 1'b1, 3'd3, 1'b1}); // ptr 2 -> 3
      tv.push_back('{1'b1, 5'b11111, 5'b11111, 1'b1, 1'b1, 3'd7, 1'b0}); // reset mid-packet
      tv.push_back('{1'b0, 5'b11111, 5'b11111, 1'b0, 1'b0, 3'd0, 1'b1}); // ptr back to 0

      foreach (tv[i]) begin
         @(negedge clk);
         rst_a = tv[i].rst; req_a = tv[i].req; elig_a = tv[i].elig;
         adv_a = tv[i].adv; tail_a = tv[i].tail;
         @(posedge clk); #1;
         eg = tv[i].exp_v ? (5'd1 << tv[i].exp_idx) : 5'd0;
         check($sformatf("a_v%0d_idx", i), 32'(idx_a), 32'(tv[i].exp_idx));
         check($sformatf("a_v%0d_valid", i), 32'(gv_a), 32'(tv[i].exp_v));
         check($sformatf("a_v%0d_grant", i), 32'(grant_a), 32'(eg));
         chk_en = 1'b1;
      end

      // LOCK_EN = 0: every transferred flit releases the grant
      step_b(1'b1, 5'b00000, 1'b0, 1'b0, 3'd7, 1'b0, "b_reset");
      step_b(1'b0, 5'b00011, 1'b0, 1'b0, 3'd0, 1'b1, "b_grant0");
      step_b(1'b0, 5'b00011, 1'b1, 1'b0, 3'd1, 1'b1, "b_rel_no_tail");
      step_b(1'b0, 5'b00011, 1'b1, 1'b0, 3'd0, 1'b1, "b_rel_wrap");
      step_b(1'b0, 5'b00011, 1'b0, 1'b0, 3'd0, 1'b1, "b_hold");
      step_b(1'b0, 5'b00000, 1'b1, 1'b0, 3'd7, 1'b0, "b_idle");

      // 8 ports: full rotation and the 4-bit no-grant code
      step_c(1'b1, 8'h00, 1'b0, 1'b0, 4'd15, 1'b0, "c_reset");
      for (int k = 0; k < 8; k++)
         step_c(1'b0, 8'hFF, 1'b1, 1'b1, 4'(k), 1'b1, $sformatf("c_rot%0d", k));
      step_c(1'b0, 8'hFF, 1'b1, 1'b1, 4'd0, 1'b1, "c_wrap");
      step_c(1'b0, 8'h80, 1'b1, 1'b1, 4'd7, 1'b1, "c_last");
      step_c(1'b0, 8'h00, 1'b1, 1'b1, 4'd15, 1'b0, "c_idle");

      @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
